multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore-style control FSM for the multicycle MIPS datapath. It replaces the single-cycle opcode decode with a per-instruction state sequence. It drives the register-file, ALU, memory-address and PC-update selects, and generates the PC enable from the ALU `zero` flag. It sits beside the ALU decoder, which consumes `aluop` unchanged.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `op`  in  6  opcode field from the instruction register.
- `zero`  in  1  ALU zero flag, combinational from datapath.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `irwrite`  out  1  instruction register load.
- `memwrite`  out  1  data memory write.
- `memtoreg`  out  1  register write data: 0 = ALUOut, 1 = memory data.
- `regdst`  out  1  destination register: 0 = rt, 1 = rd.
- `regwrite`  out  1  register file write.
- `alusrca`  out  1  ALU A input: 0 = PC, 1 = rs.
- `alusrcb`  out  2  ALU B input: 00 = rt, 01 = constant 4, 10 = extended immediate, 11 = immediate shifted left by 2.
- `zeroext`  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
- `pcsrc`  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `aluop`  out  3  ALU operation: 000 = add, 001 = sub, 010 = or, 011 = and, 100 = use funct field.
- `pcen`  out  1  PC register enable.
- `instr_done`  out  1  one-cycle pulse in the last state of each instruction.
- `illegal`  out  1  sticky flag; set when an unknown opcode is decoded.

## Operation
- State register is 4 bits. Encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BREX=8, IMMEX=9, IMMWB=10, JEX=11
  - Encodings 12-15 go to FETCH on the next edge.
- `op` is latched into `op_l` on the clock edge leaving DECODE. All states after DECODE use `op_l` only.
- Transitions:
  - FETCH→DECODE always.
  - DECODE branches on `op`:
    - 100011 or 101011 → MEMADR
    - 000000 → RTYPEEX
    - 000100 or 000101 → BREX
    - 001000, 001101 or 001100 → IMMEX
    - 000010 → JEX
    - any other opcode → FETCH, and `illegal` sets.
  - MEMADR → MEMRD if `op_l`=LW, else MEMWR.
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB.
  - IMMEX→IMMWB.
  - MEMWB, MEMWR, RTYPEWB, BREX, IMMWB and JEX → FETCH.
- Asserted outputs per state. Every output not listed is 0.
  - FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01.
  - DECODE: `alusrcb`=11.
  - MEMADR: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `iord`=1.
  - MEMWB: `memtoreg`=1, `regwrite`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=1, `aluop`=100.
  - RTYPEWB: `regdst`=1, `regwrite`=1.
  - BREX: `alusrca`=1, `aluop`=001, `pcsrc`=01, `branch`=1.
  - IMMEX: `alusrca`=1, `alusrcb`=10. Per `op_l`:
    - ADDI: `aluop`=000, `zeroext`=0.
    - ORI: `aluop`=010, `zeroext`=1.
    - ANDI: `aluop`=011, `zeroext`=1.
  - IMMWB: `regwrite`=1. Hold IMMEX's `alusrca`, `alusrcb`, `aluop` and `zeroext` values.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- `pcwrite` and `branch` are internal signals.
- `pcen` = `pcwrite` | (`branch` & (`zero` ^ `isbne`)), where `isbne` = (`op_l`==000101).
- `instr_done` = 1 in MEMWB, MEMWR, RTYPEWB, BREX, IMMWB and JEX. It is also 1 in DECODE when the opcode is illegal.
- `illegal` clears only on reset.

## Timing
- Reset values (asynchronous, effective immediately):
  - State = FETCH, `op_l`=0, `illegal`=0.
  - While `reset` is high, `irwrite`, `pcen`, `memwrite`, `regwrite` and `instr_done` are forced to 0. All other outputs take their FETCH values.
- First FETCH actions (IR load, PC+4) occur on the first rising edge after `reset` deasserts.
- Instruction latency, counting FETCH as cycle 1:
  - LW 5
  - SW 4
  - R-type 4
  - ADDI/ORI/ANDI 4
  - BEQ/BNE 3
  - J 3
  - illegal 2
- `pcen` is combinational within the cycle. In BREX it follows `zero` in that same cycle.
- Reset asserted mid-instruction aborts the instruction. No write strobe may glitch high after `reset` rises.
- `op` changes outside DECODE have no effect.

## Test plan
- Reset, then LW (op=100011) → states 0,1,2,3,4,0. `iord`=1 in MEMRD. `regwrite`=1 and `memtoreg`=1 only in MEMWB. `instr_done` pulses in cycle 5.
- SW, then R-type → SW gives `memwrite`=1 for exactly one cycle in state 5. R-type gives `aluop`=100 in RTYPEEX, then `regdst`=1 and `regwrite`=1 in RTYPEWB.
- Branches in BREX:
  - BEQ with `zero`=1 → `pcen`=1; with `zero`=0 → `pcen`=0.
  - BNE with `zero`=0 → `pcen`=1; with `zero`=1 → `pcen`=0.
- ORI and ANDI → IMMEX/IMMWB show `aluop`=010 and 011 respectively, with `zeroext`=1. ADDI shows `aluop`=000, `zeroext`=0. `op` is toggled to 000000 during IMMEX and must not change outputs.
- op=111111 → DECODE returns to FETCH next cycle with `instr_done`=1 and `illegal`=1. The flag stays set across a following valid J (3 cycles, `pcsrc`=10 in JEX).
- `reset` pulsed during MEMWR → `memwrite` drops to 0 asynchronously and the state is FETCH. After release, the next instruction executes normally.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath: sequences each instruction
// through per-opcode states and drives datapath selects, write strobes and PC enable.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] pcsrc,
    output logic [2:0] aluop,
    output logic       pcen,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] RTYPEEX = 4'd6;
    localparam logic [3:0] RTYPEWB = 4'd7;
    localparam logic [3:0] BREX    = 4'd8;
    localparam logic [3:0] IMMEX   = 4'd9;
    localparam logic [3:0] IMMWB   = 4'd10;
    localparam logic [3:0] JEX     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [5:0] op_l;
    logic       op_valid;

    logic       pcwrite;
    logic       branch;
    logic       isbne;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic       done_s;
    logic [2:0] imm_aluop;
    logic       imm_zeroext;

    always_comb begin
        op_valid = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ORI, OP_ANDI, OP_J: op_valid = 1'b1;
            default:                        op_valid = 1'b0;
        endcase
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:             next_state = MEMADR;
                    OP_RTYPE:                 next_state = RTYPEEX;
                    OP_BEQ, OP_BNE:           next_state = BREX;
                    OP_ADDI, OP_ORI, OP_ANDI: next_state = IMMEX;
                    OP_J:                     next_state = JEX;
                    default:                  next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (op_l == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
            IMMEX:   next_state = IMMWB;
            default: next_state = FETCH;
        endcase
    end

    // op is sampled only while leaving DECODE; later states see op_l alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            op_l    <= 6'd0;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE) begin
                op_l <= op;
                if (!op_valid)
                    illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        imm_aluop   = 3'b000;
        imm_zeroext = 1'b0;
        case (op_l)
            OP_ORI: begin
                imm_aluop   = 3'b010;
                imm_zeroext = 1'b1;
            end
            OP_ANDI: begin
                imm_aluop   = 3'b011;
                imm_zeroext = 1'b1;
            end
            default: begin
                imm_aluop   = 3'b000;
                imm_zeroext = 1'b0;
            end
        endcase
    end

    always_comb begin
        iord       = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        regwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        zeroext    = 1'b0;
        pcsrc      = 2'b00;
        aluop      = 3'b000;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        done_s     = 1'b0;
        case (state)
            FETCH: begin
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
                alusrcb   = 2'b01;
            end
            DECODE: begin
                alusrcb = 2'b11;
                done_s  = !op_valid;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 3'b100;
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            BREX: begin
                alusrca = 1'b1;
                aluop   = 3'b001;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                done_s  = 1'b1;
            end
            IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = imm_aluop;
                zeroext = imm_zeroext;
            end
            IMMWB: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                aluop      = imm_aluop;
                zeroext    = imm_zeroext;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                done_s  = 1'b1;
            end
            default: ;
        endcase
    end

    assign isbne = (op_l == OP_BNE);

    // strobes are gated by reset directly so none can pulse while reset is high
    assign irwrite    = irwrite_s  & ~reset;
    assign memwrite   = memwrite_s & ~reset;
    assign regwrite   = regwrite_s & ~reset;
    assign instr_done = done_s     & ~reset;
    assign pcen       = (pcwrite | (branch & (zero ^ isbne))) & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction stream checked cycle by cycle against a per-instruction
// behavioural model of the control outputs, including reset aborts.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
        logic       pcen;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BR = 3, C_IMM = 4, C_J = 5, C_ILL = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    ctl_t       obs;

    int    n_checks = 0;
    int    n_errors = 0;
    string ctx = "";
    logic  ill_exp = 1'b0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .iord       (obs.iord),
        .irwrite    (obs.irwrite),
        .memwrite   (obs.memwrite),
        .memtoreg   (obs.memtoreg),
        .regdst     (obs.regdst),
        .regwrite   (obs.regwrite),
        .alusrca    (obs.alusrca),
        .alusrcb    (obs.alusrcb),
        .zeroext    (obs.zeroext),
        .pcsrc      (obs.pcsrc),
        .aluop      (obs.aluop),
        .pcen       (obs.pcen),
        .instr_done (obs.instr_done),
        .illegal    (obs.illegal)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got %0h expected %0h", ctx, tag, got, exp);
        end
    endtask

    task automatic check_ctl(input ctl_t e);
        check_val("iord",       8'(obs.iord),       8'(e.iord));
        check_val("irwrite",    8'(obs.irwrite),    8'(e.irwrite));
        check_val("memwrite",   8'(obs.memwrite),   8'(e.memwrite));
        check_val("memtoreg",   8'(obs.memtoreg),   8'(e.memtoreg));
        check_val("regdst",     8'(obs.regdst),     8'(e.regdst));
        check_val("regwrite",   8'(obs.regwrite),   8'(e.regwrite));
        check_val("alusrca",    8'(obs.alusrca),    8'(e.alusrca));
        check_val("alusrcb",    8'(obs.alusrcb),    8'(e.alusrcb));
        check_val("zeroext",    8'(obs.zeroext),    8'(e.zeroext));
        check_val("pcsrc",      8'(obs.pcsrc),      8'(e.pcsrc));
        check_val("aluop",      8'(obs.aluop),      8'(e.aluop));
        check_val("pcen",       8'(obs.pcen),       8'(e.pcen));
        check_val("instr_done", 8'(obs.instr_done), 8'(e.instr_done));
        check_val("illegal",    8'(obs.illegal),    8'(e.illegal));
    endtask

    function automatic int op_class(input logic [5:0] o);
        case (o)
            6'b100011:                     return C_LW;
            6'b101011:                     return C_SW;
            6'b000000:                     return C_R;
            6'b000100, 6'b000101:          return C_BR;
            6'b001000, 6'b001101, 6'b001100: return C_IMM;
            6'b000010:                     return C_J;
            default:                       return C_ILL;
        endcase
    endfunction

    function automatic int latency(input int cls);
        case (cls)
            C_LW:                return 5;
            C_SW, C_R, C_IMM:    return 4;
            C_BR, C_J:           return 3;
            default:             return 2;
        endcase
    endfunction

    // Expected outputs in cycle k (FETCH = 1) of an instruction with opcode o
    function automatic ctl_t expect_cycle(input logic [5:0] o, input int k,
                                          input logic z, input logic ill);
        ctl_t e;
        int   cls;
        cls = op_class(o);
        e = '0;
        e.illegal = ill;
        if (k == 1) begin
            e.irwrite = 1'b1;
            e.pcen    = 1'b1;
            e.alusrcb = 2'b01;
        end else if (k == 2) begin
            e.alusrcb    = 2'b11;
            e.instr_done = (cls == C_ILL);
        end else begin
            e.instr_done = (k == latency(cls));
            case (cls)
                C_LW, C_SW: begin
                    if (k == 3) begin
                        e.alusrca = 1'b1;
                        e.alusrcb = 2'b10;
                    end else begin
                        e.iord     = (cls == C_SW) || (k == 4);
                        e.memwrite = (cls == C_SW);
                        e.memtoreg = (k == 5);
                        e.regwrite = (k == 5);
                    end
                end
                C_R: begin
                    e.alusrca  = (k == 3);
                    e.aluop    = (k == 3) ? 3'b100 : 3'b000;
                    e.regdst   = (k == 4);
                    e.regwrite = (k == 4);
                end
                C_BR: begin
                    e.alusrca = 1'b1;
                    e.aluop   = 3'b001;
                    e.pcsrc   = 2'b01;
                    e.pcen    = (o == 6'b000101) ? ~z : z;
                end
                C_IMM: begin
                    e.alusrca  = 1'b1;
                    e.alusrcb  = 2'b10;
                    e.aluop    = (o == 6'b001101) ? 3'b010 : (o == 6'b001100) ? 3'b011 : 3'b000;
                    e.zeroext  = (o != 6'b001000);
                    e.regwrite = (k == 4);
                end
                C_J: begin
                    e.pcsrc = 2'b10;
                    e.pcen  = 1'b1;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic ctl_t expect_reset();
        ctl_t e;
        e = '0;
        e.alusrcb = 2'b01;
        return e;
    endfunction

    // Entered and left at posedge+2 of a cycle; abort_k > 0 pulses reset in that cycle
    task automatic run_instr(input logic [5:0] o, input logic zsel, input int abort_k);
        int lat;
        lat = latency(op_class(o));
        for (int k = 1; k <= lat; k++) begin
            if (k == 2)
                op = o;
            else
                op = ($urandom_range(0, 1) == 1) ? 6'b000000 : 6'($urandom_range(0, 63));
            zero = (k == 3) ? zsel : 1'($urandom_range(0, 1));
            #2;
            ctx = $sformatf("op=%b c%0d", o, k);
            check_ctl(expect_cycle(o, k, zero, ill_exp));
            if (k == abort_k) begin
                #1 reset = 1'b1;
                #1;
                ctx = $sformatf("op=%b abort c%0d", o, k);
                check_ctl(expect_reset());
                @(posedge clk);
                #2 reset = 1'b0;
                ill_exp = 1'b0;
                return;
            end
            @(posedge clk);
            #2;
        end
        if (op_class(o) == C_ILL)
            ill_exp = 1'b1;
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] valid_ops [9];
        logic [5:0] r;
        valid_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                      6'b001000, 6'b001101, 6'b001100, 6'b000010};
        if ($urandom_range(0, 9) != 0)
            return valid_ops[$urandom_range(0, 8)];
        r = 6'($urandom_range(0, 63));
        for (int i = 0; i < 64 && op_class(r) != C_ILL; i++)
            r = 6'($urandom_range(0, 63));
        return (op_class(r) == C_ILL) ? r : 6'b111111;
    endfunction

    initial begin
        logic [5:0] o;
        repeat (2) @(posedge clk);
        #2;
        ctx = "in reset";
        check_ctl(expect_reset());
        reset = 1'b0;

        run_instr(6'b100011, 1'b0, 0);
        run_instr(6'b101011, 1'b0, 0);
        run_instr(6'b000000, 1'b0, 0);
        run_instr(6'b000100, 1'b1, 0);
        run_instr(6'b000100, 1'b0, 0);
        run_instr(6'b000101, 1'b0, 0);
        run_instr(6'b000101, 1'b1, 0);
        run_instr(6'b001101, 1'b0, 0);
        run_instr(6'b001100, 1'b0, 0);
        run_instr(6'b001000, 1'b0, 0);
        run_instr(6'b111111, 1'b0, 0);
        run_instr(6'b000010, 1'b0, 0);
        run_instr(6'b101011, 1'b0, 4);
        run_instr(6'b100011, 1'b0, 0);

        for (int n = 0; n < 300; n++) begin
            o = pick_op();
            if ($urandom_range(0, 15) == 0)
                run_instr(o, 1'($urandom_range(0, 1)), int'($urandom_range(1, latency(op_class(o)))));
            else
                run_instr(o, 1'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
